data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate L1 data cache for the pipelined RV32I core.
- Sits in the Memory stage between the Memory pipeline register (ALUResultM, WriteDataM, MemWriteM, ByteAddrM) and a variable-latency backing data memory.
- Serves load hits combinationally in the same cycle.
- Raises a stall that the hazard unit ORs into its stall terms for F, D, E and M; a bubble is inserted into W while the stall is high.

---
 rtl/data_cache.sv | 159 +++++++++++++++
 tb/tb_data_cache.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Brief    : Direct-mapped, write-through, no-write-allocate L1 data cache
//            with same-cycle load hits and a stall for misses and stores.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic                  ByteAddrM,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  StallM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_byte,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = DATA_WIDTH - c_IDX_W - 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_MISS = 2'd1,
        S_WR_THRU = 2'd2,
        S_WR_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SETS-1:0]       r_valid;
    logic [c_TAG_W-1:0]    r_tag  [SETS];
    logic [DATA_WIDTH-1:0] r_data [SETS];

    logic [c_IDX_W-1:0]    w_idx;
    logic [c_TAG_W-1:0]    w_tag;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_line;
    logic [7:0]            w_byte;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_refill;
    logic                  w_wr_update;

    assign w_idx  = A[c_IDX_W+1:2];
    assign w_tag  = A[DATA_WIDTH-1:c_IDX_W+2];
    assign w_line = r_data[w_idx];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_byte = w_line[{A[1:0], 3'b000} +: 8];

    // Little-endian lane merge for byte stores that hit
    always_comb begin
        w_merged = w_line;
        w_merged[{A[1:0], 3'b000} +: 8] = WD[7:0];
    end

    always_comb begin
        w_next      = r_state;
        StallM      = 1'b0;
        RD          = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_byte    = 1'b0;
        mem_addr    = {A[DATA_WIDTH-1:2], 2'b00};
        mem_wdata   = WD;
        w_refill    = 1'b0;
        w_wr_update = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemWriteM) begin
                    StallM = 1'b1;
                    w_next = S_WR_THRU;
                end else if (MemReadM) begin
                    if (w_hit) begin
                        RD = ByteAddrM ? {{(DATA_WIDTH-8){1'b0}}, w_byte} : w_line;
                    end else begin
                        StallM = 1'b1;
                        w_next = S_RD_MISS;
                    end
                end
            end
            S_RD_MISS: begin
                mem_req = 1'b1;
                StallM  = 1'b1;
                if (mem_ready) begin
                    w_refill = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            S_WR_THRU: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_byte = ByteAddrM;
                mem_addr = A;
                StallM   = 1'b1;
                if (mem_ready) begin
                    w_wr_update = w_hit;
                    w_next      = S_WR_DONE;
                end
            end
            S_WR_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Reset takes effect on outputs immediately, abandoning any transaction
        if (rst) begin
            w_next      = S_IDLE;
            StallM      = 1'b0;
            RD          = '0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            mem_byte    = 1'b0;
            w_refill    = 1'b0;
            w_wr_update = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_refill) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; validity alone qualifies them
    always_ff @(posedge clk) begin
        if (w_refill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_rdata;
        end else if (w_wr_update) begin
            r_data[w_idx] <= ByteAddrM ? w_merged : WD;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache
// Brief    : Self-checking bench for data_cache: directed vector table, reset
//            abort sequence and randomized traffic against a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM, ByteAddrM;
    logic [31:0] A, WD, RD;
    logic        StallM, mem_req, mem_we, mem_byte;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    data_cache #(.DATA_WIDTH(32), .SETS(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReadM  (MemReadM),
        .MemWriteM (MemWriteM),
        .ByteAddrM (ByteAddrM),
        .A         (A),
        .WD        (WD),
        .RD        (RD),
        .StallM    (StallM),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference: the cache is transparent, so loads return backing-memory
    // contents; only residency (index -> tag) is tracked to predict stalls.
    logic [31:0] mem [logic [31:0]];
    bit          m_valid [256];
    logic [21:0] m_tag   [256];

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic void model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endfunction

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endfunction

    function automatic void predict(input logic rd, input logic wr, input logic bt,
                                    input logic [31:0] a, input int lat,
                                    output logic [31:0] er, output int es);
        logic [31:0] word;
        bit          hit;
        hit  = m_valid[a[9:2]] && (m_tag[a[9:2]] == a[31:10]);
        word = mem_rd({a[31:2], 2'b00});
        er   = 32'h0;
        es   = 0;
        if (wr) begin
            es = lat + 1;
        end else if (rd) begin
            es = hit ? 0 : lat + 1;
            er = bt ? ((word >> (8 * int'(a[1:0]))) & 32'hFF) : word;
        end
    endfunction

    function automatic void commit(input logic rd, input logic wr, input logic bt,
                                   input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] wa, w;
        bit          hit;
        wa  = {a[31:2], 2'b00};
        hit = m_valid[a[9:2]] && (m_tag[a[9:2]] == a[31:10]);
        if (wr) begin
            w = mem_rd(wa);
            if (bt) w[8 * int'(a[1:0]) +: 8] = wd[7:0];
            else    w = wd;
            mem[wa] = w;
        end else if (rd && !hit) begin
            m_valid[a[9:2]] = 1'b1;
            m_tag[a[9:2]]   = a[31:10];
        end
    endfunction

    // Presents one request and plays the backing memory with latency 'lat'
    // (mem_ready pulses in the lat-th cycle of mem_req). Entered/left at posedge+1.
    task automatic access(input logic rd, input logic wr, input logic bt,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          input logic [31:0] exp_rd, input int exp_stalls, input string tag);
        int          stalls;
        int          req_n;
        bit          done;
        logic [31:0] got_rd;
        logic        got_req;
        stalls = 0; req_n = 0; done = 0; got_rd = '0; got_req = 1'b0;
        MemReadM = rd; MemWriteM = wr; ByteAddrM = bt; A = a; WD = wd;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (!StallM) begin
                done = 1; got_rd = RD; got_req = mem_req;
                break;
            end
            stalls++;
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    check({tag, " mem_we"},   {31'b0, mem_we}, {31'b0, wr});
                    check({tag, " mem_addr"}, mem_addr, wr ? a : {a[31:2], 2'b00});
                    if (wr) begin
                        check({tag, " mem_byte"},  {31'b0, mem_byte}, {31'b0, bt});
                        check({tag, " mem_wdata"}, mem_wdata, wd);
                    end
                end
                if (req_n == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = wr ? $urandom : mem_rd({a[31:2], 2'b00});
                end
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
        if (!done) begin
            n_total++;
            $display("FAIL %s timeout: StallM still %b after 64 cycles, required release", tag, StallM);
        end else begin
            check({tag, " stalls"}, stalls, exp_stalls);
            check({tag, " RD"}, got_rd, exp_rd);
            check({tag, " no req on release"}, {31'b0, got_req}, 32'h0);
            @(posedge clk); #1;
        end
        MemReadM = 1'b0; MemWriteM = 1'b0; ByteAddrM = 1'b0;
    endtask

    typedef struct {
        logic        rd, wr, bt;
        logic [31:0] a, wd;
        int          lat;
        logic [31:0] exp_rd;
        int          exp_stalls;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] er;
        int          es;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,         3, 32'hDEADBEEF, 4};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,         1, 32'hDEADBEEF, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h103,  32'h0,         1, 32'h000000DE, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h100,  32'h0,         1, 32'h000000EF, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h101,  32'hAAAAAA55,  2, 32'h0,        3};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,         1, 32'hDEAD55EF, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h500,  32'h0,         2, 32'h12345678, 3};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,         1, 32'hDEAD55EF, 2};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h2000, 32'hCAFEF00D,  1, 32'h0,        2};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h2000, 32'h0,         2, 32'hCAFEF00D, 3};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h2000, 32'h0,         1, 32'hCAFEF00D, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h100,  32'h0,         1, 32'h0,        0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 32'h502,  32'h0,         1, 32'h00000034, 2};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h100,  32'h11223344,  1, 32'h0,        2};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,         1, 32'h11223344, 2};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 32'h100,  32'h0BADF00D,  2, 32'h0,        3};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h100,  32'h0,         1, 32'h0BADF00D, 0};

        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h500] = 32'h12345678;
        model_reset();

        // Reset with a pending load on the inputs: outputs must read as reset values
        rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; ByteAddrM = 1'b0;
        A = 32'h100; WD = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset StallM",  {31'b0, StallM},  32'h0);
        check("reset mem_req", {31'b0, mem_req}, 32'h0);
        check("reset mem_we",  {31'b0, mem_we},  32'h0);
        check("reset RD",      RD,               32'h0);
        @(posedge clk); #1;
        rst = 1'b0; MemReadM = 1'b0;

        for (int i = 0; i < 17; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].bt, tbl[i].a, tbl[i].wd, tbl[i].lat,
                   tbl[i].exp_rd, tbl[i].exp_stalls, $sformatf("vec%0d", i));
            commit(tbl[i].rd, tbl[i].wr, tbl[i].bt, tbl[i].a, tbl[i].wd);
        end

        // Reset while a read miss waits on memory, then a late mem_ready pulse
        MemReadM = 1'b1; A = 32'h600;
        @(negedge clk);
        check("abort miss stall", {31'b0, StallM}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort req pending", {31'b0, mem_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; MemReadM = 1'b0;
        @(negedge clk);
        check("abort rst-cycle req", {31'b0, mem_req}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("abort req dropped",   {31'b0, mem_req}, 32'h0);
        check("abort stall dropped", {31'b0, StallM},  32'h0);
        mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        predict(1'b1, 1'b0, 1'b0, 32'h600, 2, er, es);
        access(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 2, er, es, "post-abort lw 0x600");
        commit(1'b1, 1'b0, 1'b0, 32'h600, 32'h0);
        predict(1'b1, 1'b0, 1'b0, 32'h100, 1, er, es);
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1, er, es, "post-abort lw 0x100");
        commit(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);

        // Randomized traffic over a small address pool to force hits and conflicts
        for (int n = 0; n < 250; n++) begin
            int          op, lat;
            logic        rd, wr, bt;
            logic [31:0] a, wd;
            op  = int'($urandom_range(0, 9));
            rd  = (op <= 4) || (op == 8);
            wr  = (op >= 5) && (op <= 8);
            bt  = 1'($urandom_range(0, 1));
            lat = int'($urandom_range(1, 4));
            a   = 32'h4000 + ($urandom_range(0, 3) << 10) + ($urandom_range(0, 7) << 2)
                  + (bt ? $urandom_range(0, 3) : 0);
            wd  = $urandom;
            predict(rd, wr, bt, a, lat, er, es);
            access(rd, wr, bt, a, wd, lat, er, es, $sformatf("rand%0d", n));
            commit(rd, wr, bt, a, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
